// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and lane helpers for the memory access stage.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFFFC00;
  localparam logic [31:0] IO_MASK         = 32'hFFFFFC00;

  typedef enum logic [1:0] {
    IDLE,
    RAM_WAIT,
    IO_ACC,
    DONE
  } mem_state_t;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated so every enabled lane already holds the operand.
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory/IO access stage: classifies each ALU-addressed load/store, runs it on the
// handshake data RAM or the single-cycle IO window, and returns extended load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int          RAM_ADDR_W     = 14,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] IO_BASE        = IO_BASE_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           ALU_Result,
  input  logic [31:0]           Read_data_2,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Mem_size,
  input  logic                  Load_unsigned,
  output logic                  Stall,
  output logic [31:0]           Wb_data,
  output logic                  Wb_valid,
  output logic                  Mem_err,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [3:0]            ram_be,
  output logic [31:0]           ram_wdata,
  input  logic                  ram_ack,
  input  logic [31:0]           ram_rdata,
  output logic                  io_rd,
  output logic                  io_wr,
  output logic [7:0]            io_addr,
  output logic [31:0]           io_wdata,
  input  logic [31:0]           io_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_addr_lo;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic             r_write;

  logic             w_req;
  logic             w_is_io;
  logic             w_misaligned;
  logic             w_illegal;
  logic [31:0]      w_rdata;
  logic [31:0]      w_load;

  assign w_req        = MemRead | MemWrite;
  assign w_is_io      = (ALU_Result & IO_MASK) == (IO_BASE & IO_MASK);
  assign w_misaligned = ((Mem_size == SZ_HALF) && ALU_Result[0]) ||
                        ((Mem_size == SZ_WORD) && (ALU_Result[1:0] != 2'b00));
  assign w_illegal    = (MemRead & MemWrite) || (Mem_size == SZ_ILL) || w_misaligned ||
                        (w_is_io && (Mem_size != SZ_WORD));

  // Stall is forced low while reset is held, even if a request is still presented.
  assign Stall   = reset & (((r_state == IDLE) & w_req) | (r_state == RAM_WAIT) |
                            (r_state == IO_ACC));
  assign w_rdata = (r_state == IO_ACC) ? io_rdata : ram_rdata;

  load_align u_load_align (
    .i_rdata    (w_rdata),
    .i_addr_lo  (r_addr_lo),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr_lo  <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_write    <= 1'b0;
      ram_req    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_be     <= '0;
      ram_wdata  <= '0;
      io_rd      <= 1'b0;
      io_wr      <= 1'b0;
      io_addr    <= '0;
      io_wdata   <= '0;
      Wb_data    <= '0;
      Wb_valid   <= 1'b0;
      Mem_err    <= 1'b0;
    end else begin
      Wb_valid <= 1'b0;
      Mem_err  <= 1'b0;
      io_rd    <= 1'b0;
      io_wr    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr_lo  <= ALU_Result[1:0];
            r_size     <= Mem_size;
            r_unsigned <= Load_unsigned;
            r_write    <= MemWrite;
            if (w_illegal) begin
              r_state  <= DONE;
              Wb_valid <= 1'b1;
              Mem_err  <= 1'b1;
              Wb_data  <= '0;
            end else if (w_is_io) begin
              r_state <= IO_ACC;
              io_rd   <= MemRead;
              io_wr   <= MemWrite;
              io_addr <= ALU_Result[9:2];
              if (MemWrite) io_wdata <= Read_data_2;
            end else begin
              r_state   <= RAM_WAIT;
              r_cnt     <= '0;
              ram_req   <= 1'b1;
              ram_we    <= MemWrite;
              ram_addr  <= ALU_Result[RAM_ADDR_W+1:2];
              ram_be    <= byte_enables(Mem_size, ALU_Result[1:0]);
              ram_wdata <= lane_replicate(Mem_size, Read_data_2);
            end
          end
        end
        // An ack on the final wait cycle still completes the access cleanly.
        RAM_WAIT: begin
          if (ram_ack) begin
            r_state  <= DONE;
            ram_req  <= 1'b0;
            ram_we   <= 1'b0;
            Wb_valid <= 1'b1;
            Wb_data  <= r_write ? '0 : w_load;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_state  <= DONE;
            ram_req  <= 1'b0;
            ram_we   <= 1'b0;
            Wb_valid <= 1'b1;
            Mem_err  <= 1'b1;
            Wb_data  <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        IO_ACC: begin
          r_state  <= DONE;
          Wb_valid <= 1'b1;
          Wb_data  <= r_write ? '0 : w_load;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
